// File: rtl/decode_stage_hs.sv
// IF/ID stage with a valid/ready handshake, flush, load-use hold and a banked regfile.
// Define DECODE_PERF_EN to add the stall_cnt/bubble_cnt performance counters.
module decode_stage_hs #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 6,
    parameter int IMM_W  = 16,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [5:0]        in_funct,
    input  logic [PC_W-1:0]   in_pc4,
    input  logic [REG_AW-2:0] in_rs1,
    input  logic [REG_AW-2:0] in_rs2,
    input  logic [REG_AW-2:0] in_rd,
    input  logic              in_fp,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_ld_valid,
    input  logic [REG_AW-1:0] ex_ld_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_opcode,
    output logic [5:0]        out_funct,
    output logic [PC_W-1:0]   out_pc4,
    output logic [IMM_W-1:0]  out_imm,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_a,
`ifdef DECODE_PERF_EN
    output logic [DATA_W-1:0] out_b,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`else
    output logic [DATA_W-1:0] out_b
`endif
);

    localparam int NREG = 2 ** REG_AW;

    logic              r_valid;
    logic [5:0]        r_opcode;
    logic [5:0]        r_funct;
    logic [PC_W-1:0]   r_pc4;
    logic [IMM_W-1:0]  r_imm;
    logic [REG_AW-2:0] r_rs1;
    logic [REG_AW-2:0] r_rs2;
    logic [REG_AW-2:0] r_rd;
    logic              r_fp;
    logic [DATA_W-1:0] r_rf [NREG];

    logic [REG_AW-1:0] w_ra;
    logic [REG_AW-1:0] w_rb;
    logic              w_hazard;
    logic              w_capture;
    logic              w_consume;

    assign w_ra = {r_fp, r_rs1};
    assign w_rb = {r_fp, r_rs2};

    assign w_hazard = r_valid && ex_ld_valid && (ex_ld_addr != '0) &&
                      ((ex_ld_addr == w_ra) || (ex_ld_addr == w_rb));

    assign out_valid = r_valid && !w_hazard;
    assign in_ready  = !r_valid || (out_ready && !w_hazard) || flush;
    assign w_capture = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
        end else if (flush || w_consume) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_opcode <= '0;
            r_funct  <= '0;
            r_pc4    <= '0;
            r_imm    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_fp     <= 1'b0;
        end else if (w_capture) begin
            r_opcode <= in_opcode;
            r_funct  <= in_funct;
            r_pc4    <= in_pc4;
            r_imm    <= in_imm;
            r_rs1    <= in_rs1;
            r_rs2    <= in_rs2;
            r_rd     <= in_rd;
            r_fp     <= in_fp;
        end
    end

    // Writeback is never gated by stall or flush; entry 0 stays hard zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (wb_we && (wb_addr != '0)) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        out_a = r_rf[w_ra];
        if (w_ra == '0) begin
            out_a = '0;
        end else if (wb_we && (wb_addr == w_ra)) begin
            out_a = wb_data;
        end
    end

    always_comb begin
        out_b = r_rf[w_rb];
        if (w_rb == '0) begin
            out_b = '0;
        end else if (wb_we && (wb_addr == w_rb)) begin
            out_b = wb_data;
        end
    end

    assign out_opcode = r_opcode;
    assign out_funct  = r_funct;
    assign out_pc4    = r_pc4;
    assign out_imm    = r_imm;
    assign out_rd     = {r_fp, r_rd};

`ifdef DECODE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_hazard && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!out_valid && out_ready && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed self-checking bench for decode_stage_hs.
module tb_decode_stage_hs;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [5:0]  in_funct;
    logic [31:0] in_pc4;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_fp;
    logic [15:0] in_imm;
    logic        flush;
    logic        wb_we;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_ld_valid;
    logic [5:0]  ex_ld_addr;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [5:0]  out_funct;
    logic [31:0] out_pc4;
    logic [15:0] out_imm;
    logic [5:0]  out_rd;
    logic [31:0] out_a;
    logic [31:0] out_b;
`ifdef DECODE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage_hs dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_funct   (in_funct),
        .in_pc4     (in_pc4),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_fp      (in_fp),
        .in_imm     (in_imm),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ex_ld_valid(ex_ld_valid),
        .ex_ld_addr (ex_ld_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_funct  (out_funct),
        .out_pc4    (out_pc4),
        .out_imm    (out_imm),
        .out_rd     (out_rd),
        .out_a      (out_a),
`ifdef DECODE_PERF_EN
        .out_b      (out_b),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`else
        .out_b      (out_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_opcode = '0; in_funct = '0;
        in_pc4 = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_fp = 1'b0;
        in_imm = '0; flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        ex_ld_valid = 1'b0; ex_ld_addr = '0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_tests++;
        if (out_opcode !== 6'h00 || out_pc4 !== 32'h0 || out_a !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_fields got op=%h pc4=%h a=%h want 0", out_opcode, out_pc4, out_a);
        end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_opcode = 6'h08; in_funct = 6'h15; in_pc4 = 32'h104;
        in_rs1 = 5'd5; in_rs2 = 5'd9; in_rd = 5'd3; in_imm = 16'h1234;
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_accept got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_opcode !== 6'h08 || out_pc4 !== 32'h104) begin
            n_fail++;
            $display("FAIL basic_out got v=%b op=%h pc4=%h want 1 08 104", out_valid, out_opcode, out_pc4);
        end
        n_tests++;
        if (out_funct !== 6'h15 || out_imm !== 16'h1234 || out_rd !== 6'd3) begin
            n_fail++;
            $display("FAIL basic_fields got f=%h imm=%h rd=%h want 15 1234 03", out_funct, out_imm, out_rd);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_ready_held got %b want 1", in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_bypass();
        wb_we = 1'b1; wb_addr = 6'd5; wb_data = 32'hDEADBEEF;
        #1;
        n_tests++;
        if (out_a !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL bypass_same_cycle got %h want deadbeef", out_a);
        end
        tick();
        wb_we = 1'b0;
        #1;
        n_tests++;
        if (out_a !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL bypass_file got %h want deadbeef", out_a);
        end
        // replace with rs1=0 and write to address 0
        in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        wb_we = 1'b1; wb_addr = 6'd0; wb_data = 32'hFFFFFFFF;
        #1;
        n_tests++;
        if (out_a !== 32'h0 || out_b !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL zero_reg_bypass got a=%h b=%h want 0 deadbeef", out_a, out_b);
        end
        tick();
        wb_we = 1'b0;
        #1;
        n_tests++;
        if (out_a !== 32'h0) begin
            n_fail++; $display("FAIL zero_reg_write got %h want 0", out_a);
        end
        // FP bank entry 37 is distinct from integer entry 5
        in_valid = 1'b1; in_fp = 1'b1; in_rs1 = 5'd5; in_rd = 5'd2; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_fp = 1'b0; out_ready = 1'b0;
        #1;
        n_tests++;
        if (out_a !== 32'h0 || out_rd !== 6'h22) begin
            n_fail++; $display("FAIL fp_bank got a=%h rd=%h want 0 22", out_a, out_rd);
        end
    endtask

    task automatic test_hazard();
        in_valid = 1'b1; in_opcode = 6'h0C; in_rs1 = 5'd0; in_rs2 = 5'd7; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        ex_ld_valid = 1'b1; ex_ld_addr = 6'd0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL hazard_addr0 got %b want 1", out_valid);
        end
        ex_ld_addr = 6'd7;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hazard_hold%0d got v=%b rdy=%b want 0 0", i, out_valid, in_ready);
            end
            tick();
        end
        ex_ld_valid = 1'b0; wb_we = 1'b1; wb_addr = 6'd7; wb_data = 32'h55;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_b !== 32'h55 || out_opcode !== 6'h0C) begin
            n_fail++;
            $display("FAIL hazard_release got v=%b b=%h op=%h want 1 55 0c", out_valid, out_b, out_opcode);
        end
        tick();
        wb_we = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL hazard_consumed got %b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_opcode = 6'h21; in_pc4 = 32'h200;
        tick();
        in_opcode = 6'h22; in_pc4 = 32'h204;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || out_opcode !== 6'h21 || out_pc4 !== 32'h200 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall%0d got v=%b op=%h pc4=%h rdy=%b want 1 21 200 0",
                         i, out_valid, out_opcode, out_pc4, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_opcode !== 6'h21) begin
            n_fail++; $display("FAIL bp_release got rdy=%b op=%h want 1 21", in_ready, out_opcode);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_opcode !== 6'h22 || out_pc4 !== 32'h204) begin
            n_fail++;
            $display("FAIL bp_second got v=%b op=%h pc4=%h want 1 22 204", out_valid, out_opcode, out_pc4);
        end
        tick();
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_opcode = 6'h30;
        tick();
        flush = 1'b1; in_opcode = 6'h23;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_ready got %b want 1", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_opcode !== 6'h23) begin
            n_fail++; $display("FAIL flush_new got v=%b op=%h want 1 23", out_valid, out_opcode);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_opcode = 6'h2A; in_rs1 = 5'd5;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1; in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_opcode !== 6'h00) begin
            n_fail++;
            $display("FAIL reset_mid got v=%b rdy=%b op=%h want 0 1 00", out_valid, in_ready, out_opcode);
        end
        in_valid = 1'b1; in_rs1 = 5'd5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_tests++;
        if (out_a !== 32'h0) begin
            n_fail++; $display("FAIL reset_rf got %h want 0", out_a);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

`ifdef DECODE_PERF_EN
    task automatic test_perf();
        out_ready = 1'b0; in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b1; in_rs1 = 5'd4; in_rs2 = 5'd0; in_fp = 1'b0;
        tick();
        in_valid = 1'b0;
        ex_ld_valid = 1'b1; ex_ld_addr = 6'd4;
        for (int i = 0; i < 3; i++) tick();
        ex_ld_valid = 1'b0; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) tick();
        out_ready = 1'b0;
        #1;
        n_tests++;
        if (stall_cnt !== 32'd3 || bubble_cnt !== 32'd2) begin
            n_fail++; $display("FAIL perf_counts got s=%0d b=%0d want 3 2", stall_cnt, bubble_cnt);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        n_tests++;
        if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
            n_fail++; $display("FAIL perf_flush got s=%0d b=%0d want 0 0", stall_cnt, bubble_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_hazard();
        test_backpressure();
        test_flush();
        test_reset_mid();
`ifdef DECODE_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage_hs.md
Name: decode_stage_hs

Overview:
- Parametrised successor to the fixed-width decode stage: IF/ID pipeline register with a valid/ready handshake, flush, and load-use hazard hold.
- Contains a banked register file (integer/FP) with write-through bypass from writeback.
- Sits between instruction fetch and execute; emits decoded fields plus operand data; control decoding stays in the existing control unit downstream.

Parameters:
- DATA_W, 32, register/operand width
- REG_AW, 6, register address width; MSB = FP bank select; 2**REG_AW entries
- IMM_W, 16, immediate width
- PC_W, 32, PC+4 width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_opcode  in  6  opcode
- in_funct  in  6  function field
- in_pc4  in  PC_W  PC+4
- in_rs1, in_rs2, in_rd  in  REG_AW-1 each  register specifiers
- in_fp  in  1  source bank select
- in_imm  in  IMM_W  immediate
- flush  in  1  kill held instruction (branch redirect)
- wb_we  in  1  writeback enable
- wb_addr  in  REG_AW  writeback address
- wb_data  in  DATA_W  writeback data
- ex_ld_valid  in  1  load in EX
- ex_ld_addr  in  REG_AW  load destination
- out_valid  out  1  decoded instruction valid to EX
- out_ready  in  1  EX accepts
- out_opcode, out_funct  out  6 each  held fields
- out_pc4  out  PC_W  held PC+4
- out_imm  out  IMM_W  held immediate
- out_rd  out  REG_AW  {bank, rd}
- out_a, out_b  out  DATA_W  operand data for {in_fp, rs1} / {in_fp, rs2}

Behaviour:
- Reset (reset==0 at clk edge):
  - Held valid=0; opcode, funct, pc4, imm, specifiers and fp=0.
  - All register file entries = 0.
  - out_valid=0.
- Hold register: captures in_* when in_valid && in_ready; otherwise retains its value.
- hazard = held_valid && ex_ld_valid && ex_ld_addr!=0 && (ex_ld_addr=={fp,rs1} || ex_ld_addr=={fp,rs2}).
- out_valid = held_valid && !hazard.
- in_ready = !held_valid || (out_ready && !hazard) || flush.
- Held_valid next state:
  - flush: clears held_valid. A same-cycle in_valid is still captured (new-path instruction); flush has priority over hazard.
  - Consumed (out_valid && out_ready) with no new capture: held_valid -> 0.
  - Otherwise held_valid is retained.
- Latency: one cycle IF->out. Back-to-back throughput is 1/cycle when out_ready=1 and no hazard.
- Register file:
  - Address 0 reads 0 and ignores writes.
  - Writes occur on the clock edge when wb_we=1, independent of stall or flush.
  - Reads are combinational from the held specifiers every cycle, so operands refresh while held.
  - Bypass: if wb_we && wb_addr==read addr && addr!=0, out_a/out_b = wb_data in the same cycle.
- Hazard persists for as long as ex_ld_valid matches. Release is the first cycle it deasserts; the operand then comes via bypass or the file.
- out_rd = {fp, rd}. Destination selection is done downstream.
- Reset mid-handshake drops the held instruction. in_ready=1 on the first cycle after reset.

Optional Feature:
- DECODE_PERF_EN defined:
  - Adds outputs stall_cnt[31:0] (cycles with hazard) and bubble_cnt[31:0] (cycles with !out_valid && out_ready).
  - Both counters reset to 0, saturate at all-ones, and are cleared by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then in_valid=1, opcode=0x08, pc4=0x104, out_ready=1 -> next cycle out_valid=1, out_opcode=0x08, out_pc4=0x104; in_ready stays 1.
- wb_we=1, wb_addr=5, wb_data=0xDEADBEEF while held rs1=5 -> out_a=0xDEADBEEF in the same cycle and thereafter. Write to addr 0 -> out_a stays 0 for rs1=0.
- Held rs2=7, ex_ld_valid=1, ex_ld_addr=7 for 2 cycles -> out_valid=0 and in_ready=0 for 2 cycles. Then deassert with wb 7<=0x55 -> out_valid=1, out_b=0x55.
- out_ready=0 for 3 cycles with in_valid=1 -> held fields stable, in_ready=0, no input lost; first input emitted once out_ready=1.
- flush=1 with held_valid=1 and in_valid=1 (opcode 0x23) -> old instruction never seen; next cycle out_opcode=0x23. flush with in_valid=0 -> out_valid=0.
- With DECODE_PERF_EN: 3 hazard cycles then 2 bubble cycles -> stall_cnt=3, bubble_cnt=2; flush -> both 0.
